// File: rtl/capture_pkg.sv
// Shared state encoding and default sizing for the capture controller.
package capture_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;
    localparam int NUM_CH_DEF = 5;

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} cap_state_t;

endpackage

// File: rtl/capture_addr_ctr.sv
// Sample RAM write address (wraps modulo DEPTH) and a saturating count of
// samples written since the last clear.
module capture_addr_ctr
    import capture_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [ADDR_W:0]   smpl_cnt_o
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W:0]   smpl_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q    <= '0;
            smpl_cnt_q <= '0;
        end else if (clr_i) begin
            waddr_q    <= '0;
            smpl_cnt_q <= '0;
        end else if (inc_i) begin
            waddr_q <= waddr_q + ADDR_W'(1);
            // Saturate so a long ARMED wait cannot wrap the count back into range.
            if (smpl_cnt_q != DEPTH) begin
                smpl_cnt_q <= smpl_cnt_q + (ADDR_W+1)'(1);
            end
        end
    end

    assign waddr_o    = waddr_q;
    assign smpl_cnt_o = smpl_cnt_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills the pre-trigger window, arms the channel triggers,
// waits for the combined trigger, then records the post-trigger samples.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_trig,
    input  logic              prot_trig,
    input  logic              capture_start,
    input  logic              capture_abort,
    input  logic              capture_ack,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              smpl_en,
    output logic              set_armed,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              triggered,
    output logic              capture_done,
    output cap_state_t        dbg_state
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    cap_state_t        state_q;
    logic [ADDR_W-1:0] post_cnt_q;
    logic [ADDR_W-1:0] trig_addr_q;
    logic              triggered_q;

    logic [ADDR_W:0]   smpl_cnt;
    logic [ADDR_W:0]   pre_target;
    logic [ADDR_W+1:0] smpl_next;
    logic              trigger;
    logic              start_ok;
    logic              post_empty;
    logic              pre_full;

    assign trigger    = (&ch_trig) & prot_trig;
    assign start_ok   = (state_q == IDLE) && capture_start && !capture_abort;
    assign post_empty = (post_cnt_q == '0);

    assign set_armed    = (state_q == ARMED) || (state_q == POST);
    assign capture_done = (state_q == DONE);
    assign dbg_state    = state_q;
    assign trig_addr    = trig_addr_q;
    assign triggered    = triggered_q;

    // With zero post samples requested, the single POST cycle must not write.
    always_comb begin
        we = 1'b0;
        case (state_q)
            PRE, ARMED: we = smpl_en;
            POST:       we = smpl_en && !post_empty;
            default:    we = 1'b0;
        endcase
    end

    // ">=" keeps PRE from stalling if trig_pos is moved below the count mid-fill.
    assign pre_target = DEPTH - {1'b0, trig_pos};
    assign smpl_next  = {1'b0, smpl_cnt} + (ADDR_W+2)'(1);
    assign pre_full   = we && (smpl_next >= {1'b0, pre_target});

    capture_addr_ctr #(
        .ADDR_W (ADDR_W)
    ) u_addr_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (start_ok),
        .inc_i      (we),
        .waddr_o    (waddr),
        .smpl_cnt_o (smpl_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            triggered_q <= 1'b0;
        end else if (capture_abort) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture_start) begin
                        state_q     <= PRE;
                        trig_addr_q <= '0;
                        triggered_q <= 1'b0;
                    end
                end
                PRE: begin
                    if (pre_full) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (trigger) begin
                        state_q     <= POST;
                        trig_addr_q <= waddr + ADDR_W'(we);
                        triggered_q <= 1'b1;
                        post_cnt_q  <= trig_pos;
                    end
                end
                POST: begin
                    if (post_empty) begin
                        state_q <= DONE;
                    end else if (we) begin
                        post_cnt_q <= post_cnt_q - ADDR_W'(1);
                        if (post_cnt_q == ADDR_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (capture_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl at ADDR_W=4: table-driven captures, corner-case
// sequences and random traffic, all checked against a cycle reference model.
`timescale 1ns/1ps
module tb_capture_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NCH   = 5;

    localparam int PH_IDLE  = 0;
    localparam int PH_PRE   = 1;
    localparam int PH_ARMED = 2;
    localparam int PH_POST  = 3;
    localparam int PH_DONE  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ch_trig;
    logic           prot_trig;
    logic           capture_start;
    logic           capture_abort;
    logic           capture_ack;
    logic [AW-1:0]  trig_pos;
    logic           smpl_en;
    logic           set_armed;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [AW-1:0]  trig_addr;
    logic           triggered;
    logic           capture_done;
    logic [2:0]     dbg_state;

    capture_ctrl #(.ADDR_W(AW), .NUM_CH(NCH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ch_trig       (ch_trig),
        .prot_trig     (prot_trig),
        .capture_start (capture_start),
        .capture_abort (capture_abort),
        .capture_ack   (capture_ack),
        .trig_pos      (trig_pos),
        .smpl_en       (smpl_en),
        .set_armed     (set_armed),
        .we            (we),
        .waddr         (waddr),
        .trig_addr     (trig_addr),
        .triggered     (triggered),
        .capture_done  (capture_done),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: capture phase plus plain integer bookkeeping.
    int m_phase, m_addr, m_pre, m_post_left, m_trig_addr, m_trig, n_wr, dut_wr;
    logic [AW-1:0] exp_q[$];

    typedef struct {
        int tp;
        int per;
        logic [NCH-1:0] ch;
        int trig_n;
        int exp_done;
        int exp_taddr;
        int exp_wr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_we();
        return smpl_en && (m_phase == PH_PRE || m_phase == PH_ARMED ||
                           (m_phase == PH_POST && m_post_left > 0));
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_addr = 0; m_pre = 0; m_post_left = 0;
        m_trig_addr = 0; m_trig = 0; n_wr = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit w   = m_we();
        bit trg = (ch_trig == 5'h1F) && prot_trig;
        int tp  = int'(trig_pos);
        if (w) begin
            m_addr = (m_addr + 1) % DEPTH;
            n_wr++;
        end
        if (capture_abort) begin
            m_phase = PH_IDLE;
        end else begin
            case (m_phase)
                PH_IDLE: if (capture_start) begin
                    m_phase = PH_PRE; m_addr = 0; m_pre = 0; n_wr = 0;
                    m_trig = 0; m_trig_addr = 0;
                end
                PH_PRE: if (w) begin
                    m_pre++;
                    if (m_pre >= DEPTH - tp) m_phase = PH_ARMED;
                end
                PH_ARMED: if (trg) begin
                    m_phase = PH_POST; m_trig = 1; m_trig_addr = m_addr; m_post_left = tp;
                end
                PH_POST: begin
                    if (w) m_post_left--;
                    if (m_post_left == 0) m_phase = PH_DONE;
                end
                PH_DONE: if (capture_ack) m_phase = PH_IDLE;
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    // Check every output against the model, then advance one clock.
    task automatic step();
        #2;
        chk("set_armed", set_armed, (m_phase == PH_ARMED || m_phase == PH_POST));
        chk("we", we, m_we());
        chk("capture_done", capture_done, (m_phase == PH_DONE));
        chk("triggered", triggered, m_trig);
        chk("trig_addr", trig_addr, m_trig_addr);
        chk("waddr", waddr, m_addr);
        if (m_we()) exp_q.push_back(AW'(m_addr));
        if (we === 1'b1) begin
            dut_wr++;
            if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr_addr", waddr, exp_q.pop_front());
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulses_low();
        capture_start = 1'b0; capture_abort = 1'b0; capture_ack = 1'b0;
    endtask

    task automatic start_capture(input int tp, input logic [NCH-1:0] ch);
        trig_pos = AW'(tp); ch_trig = ch;
        capture_start = 1'b1; step(); capture_start = 1'b0;
    endtask

    task automatic run_until(input int phase, input int budget);
        int c = 0;
        while (m_phase != phase && c < budget) begin
            step(); c++;
        end
        chk("phase_reached", (m_phase == phase), 1);
    endtask

    task automatic run_capture(input vec_t v);
        int  cyc = 0;
        bit  hold = 0;
        prot_trig = 1'b0; smpl_en = 1'b0; dut_wr = 0;
        start_capture(v.tp, v.ch);
        dut_wr = 0;
        while (m_phase != PH_DONE && cyc < 200) begin
            smpl_en = ((cyc % v.per) == 0);
            if (smpl_en && n_wr == v.trig_n - 1) hold = 1;
            prot_trig = hold;
            step(); cyc++;
        end
        smpl_en = 1'b0; prot_trig = 1'b0;
        #2;
        chk("tbl_done", capture_done, v.exp_done);
        chk("tbl_triggered", triggered, v.exp_done);
        chk("tbl_trig_addr", trig_addr, v.exp_taddr);
        chk("tbl_writes", dut_wr, v.exp_wr);
        if (v.exp_done != 0) capture_ack = 1'b1;
        else capture_abort = 1'b1;
        step();
        pulses_low();
        step();
    endtask

    initial begin
        vecs[0] = '{tp: 4,  per: 1, ch: 5'h1F, trig_n: 20, exp_done: 1, exp_taddr: 4,  exp_wr: 24};
        vecs[1] = '{tp: 4,  per: 4, ch: 5'h1F, trig_n: 20, exp_done: 1, exp_taddr: 4,  exp_wr: 24};
        vecs[2] = '{tp: 0,  per: 1, ch: 5'h1F, trig_n: 16, exp_done: 1, exp_taddr: 1,  exp_wr: 17};
        vecs[3] = '{tp: 4,  per: 1, ch: 5'h1E, trig_n: 14, exp_done: 0, exp_taddr: 0,  exp_wr: 200};
        vecs[4] = '{tp: 15, per: 1, ch: 5'h1F, trig_n: 1,  exp_done: 1, exp_taddr: 2,  exp_wr: 17};
        vecs[5] = '{tp: 7,  per: 2, ch: 5'h1F, trig_n: 30, exp_done: 1, exp_taddr: 14, exp_wr: 37};

        rst_n = 1'b0; pulses_low();
        ch_trig = '0; prot_trig = 1'b0; trig_pos = '0; smpl_en = 1'b0;
        model_reset();
        #3;
        chk("rst_set_armed", set_armed, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_done", capture_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_capture(vecs[i]);

        // Reset in the middle of POST clears everything immediately.
        smpl_en = 1'b1; prot_trig = 1'b1;
        start_capture(4, 5'h1F);
        run_until(PH_POST, 40);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_set_armed", set_armed, 0);
        chk("arst_we", we, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_trig_addr", trig_addr, 0);
        chk("arst_triggered", triggered, 0);
        chk("arst_done", capture_done, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(); step();

        // A trigger pulse while filling the pre-trigger window is ignored.
        smpl_en = 1'b1; prot_trig = 1'b0;
        start_capture(4, 5'h1F);
        step();
        prot_trig = 1'b1; step(); prot_trig = 1'b0;
        run_until(PH_ARMED, 40);
        chk("pre_pulse_triggered", triggered, 0);
        step(); step();
        chk("still_armed", set_armed, 1);
        prot_trig = 1'b1;
        step();
        chk("post_after_hold", (m_phase == PH_POST), 1);
        run_until(PH_DONE, 40);
        prot_trig = 1'b0; capture_ack = 1'b1; step(); pulses_low();

        // Abort during POST returns to idle without reporting completion.
        prot_trig = 1'b1;
        start_capture(6, 5'h1F);
        run_until(PH_POST, 40);
        step();
        capture_abort = 1'b1; step(); pulses_low();
        #1;
        chk("abort_set_armed", set_armed, 0);
        chk("abort_done", capture_done, 0);
        chk("abort_triggered_held", triggered, 1);
        step(); step();

        // Start colliding with abort in IDLE, and ack outside DONE.
        capture_start = 1'b1; capture_abort = 1'b1; step(); pulses_low();
        step(); step();
        chk("start_abort_idle_we", we, 0);
        capture_ack = 1'b1; step(); pulses_low();
        chk("ack_idle_armed", set_armed, 0);
        prot_trig = 1'b0;

        for (int i = 0; i < 600; i++) begin
            capture_start = ($urandom_range(0, 9) == 0);
            capture_abort = ($urandom_range(0, 39) == 0);
            capture_ack   = ($urandom_range(0, 6) == 0);
            smpl_en       = 1'($urandom_range(0, 1));
            ch_trig       = ($urandom_range(0, 4) != 0) ? 5'h1F : NCH'($urandom_range(0, 31));
            prot_trig     = ($urandom_range(0, 2) == 0);
            if (m_phase == PH_IDLE) trig_pos = AW'($urandom_range(0, 15));
            step();
        end
        pulses_low();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
